// File: rtl/morse_pkg.sv
// Shared types and constants for the Morse keyer and its code ROM.
package morse_pkg;

  localparam int unsigned CODE_W = 6;
  localparam int unsigned LEN_W  = 3;
  localparam int unsigned PAT_W  = 5;
  localparam int unsigned UNIT_W = 2;
  localparam int unsigned IDX_W  = 3;

  localparam logic [CODE_W-1:0] CODE_WORD_SPACE = CODE_W'(36);
  localparam logic [CODE_W-1:0] CODE_MAX_VALID  = CODE_W'(36);

  localparam int unsigned DOT_UNITS        = 1;
  localparam int unsigned DASH_UNITS       = 3;
  localparam int unsigned ELEM_GAP_UNITS   = 1;
  localparam int unsigned CHAR_GAP_UNITS   = 3;
  localparam int unsigned WORD_EXTRA_UNITS = 4;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    MARK     = 3'd1,
    ELEM_GAP = 3'd2,
    CHAR_GAP = 3'd3,
    WORD_GAP = 3'd4
  } state_e;

  // Pattern is left-aligned: pat[PAT_W-1] is the first element, 1 = dash.
  typedef struct packed {
    logic             valid;
    logic [LEN_W-1:0] len;
    logic [PAT_W-1:0] pat;
  } rom_entry_t;

  function automatic rom_entry_t rom_entry(input logic [LEN_W-1:0] len,
                                           input logic [PAT_W-1:0] pat);
    rom_entry_t e;
    e.valid = 1'b1;
    e.len   = len;
    e.pat   = pat;
    return e;
  endfunction

  // Number of Morse units spent in a state; dash selects the mark length.
  function automatic int unsigned state_units(input state_e st, input logic dash);
    int unsigned u;
    case (st)
      MARK:     u = dash ? DASH_UNITS : DOT_UNITS;
      ELEM_GAP: u = ELEM_GAP_UNITS;
      CHAR_GAP: u = CHAR_GAP_UNITS;
      WORD_GAP: u = WORD_EXTRA_UNITS;
      default:  u = 1;
    endcase
    return u;
  endfunction

endpackage

// File: rtl/morse_rom.sv
// Combinational symbol-code to ITU Morse element table (letters and digits only).
module morse_rom
  import morse_pkg::*;
(
  input  logic [CODE_W-1:0] code_i,
  output logic              valid_o,
  output logic [LEN_W-1:0]  len_o,
  output logic [PAT_W-1:0]  pat_o
);

  rom_entry_t ent;

  always_comb begin
    ent = '0;
    case (code_i)
      6'd0:  ent = rom_entry(3'd2, 5'b01000); // A .-
      6'd1:  ent = rom_entry(3'd4, 5'b10000); // B -...
      6'd2:  ent = rom_entry(3'd4, 5'b10100); // C -.-.
      6'd3:  ent = rom_entry(3'd3, 5'b10000);
      6'd4:  ent = rom_entry(3'd1, 5'b00000);
      6'd5:  ent = rom_entry(3'd4, 5'b00100);
      6'd6:  ent = rom_entry(3'd3, 5'b11000);
      6'd7:  ent = rom_entry(3'd4, 5'b00000);
      6'd8:  ent = rom_entry(3'd2, 5'b00000);
      6'd9:  ent = rom_entry(3'd4, 5'b01110);
      6'd10: ent = rom_entry(3'd3, 5'b10100);
      6'd11: ent = rom_entry(3'd4, 5'b01000);
      6'd12: ent = rom_entry(3'd2, 5'b11000);
      6'd13: ent = rom_entry(3'd2, 5'b10000);
      6'd14: ent = rom_entry(3'd3, 5'b11100);
      6'd15: ent = rom_entry(3'd4, 5'b01100);
      6'd16: ent = rom_entry(3'd4, 5'b11010);
      6'd17: ent = rom_entry(3'd3, 5'b01000);
      6'd18: ent = rom_entry(3'd3, 5'b00000);
      6'd19: ent = rom_entry(3'd1, 5'b10000);
      6'd20: ent = rom_entry(3'd3, 5'b00100);
      6'd21: ent = rom_entry(3'd4, 5'b00010);
      6'd22: ent = rom_entry(3'd3, 5'b01100);
      6'd23: ent = rom_entry(3'd4, 5'b10010);
      6'd24: ent = rom_entry(3'd4, 5'b10110);
      6'd25: ent = rom_entry(3'd4, 5'b11000);
      6'd26: ent = rom_entry(3'd5, 5'b11111); // digit 0
      6'd27: ent = rom_entry(3'd5, 5'b01111);
      6'd28: ent = rom_entry(3'd5, 5'b00111);
      6'd29: ent = rom_entry(3'd5, 5'b00011);
      6'd30: ent = rom_entry(3'd5, 5'b00001);
      6'd31: ent = rom_entry(3'd5, 5'b00000);
      6'd32: ent = rom_entry(3'd5, 5'b10000);
      6'd33: ent = rom_entry(3'd5, 5'b11000);
      6'd34: ent = rom_entry(3'd5, 5'b11100);
      6'd35: ent = rom_entry(3'd5, 5'b11110);
      default: ent = '0;
    endcase
  end

  assign valid_o = ent.valid;
  assign len_o   = ent.len;
  assign pat_o   = ent.pat;

endmodule

// File: rtl/morse_keyer.sv
// Morse transmitter: accepts one symbol code per handshake and keys it onto dout
// with unit timing; the next code is taken on the final gap cycle for exact spacing.
module morse_keyer
  import morse_pkg::*;
#(
  parameter int unsigned UNIT_CYCLES = 1,
  parameter int unsigned PRESC_W     = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [CODE_W-1:0] in_code,
  output logic              in_ready,
  output logic              dout,
  output logic              busy,
  output logic              elem_dot,
  output logic              elem_dash,
  output logic              err
);

  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(UNIT_CYCLES - 1);

  state_e             state_q, state_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [UNIT_W-1:0]  unit_q, unit_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [PAT_W-1:0]   pat_q, pat_d;
  logic               dout_q, dout_d;
  logic               busy_q, busy_d;
  logic               ready_q, ready_d;
  logic               dot_q, dot_d;
  logic               dash_q, dash_d;
  logic               err_q, err_d;

  logic               rom_valid;
  logic [LEN_W-1:0]   rom_len;
  logic [PAT_W-1:0]   rom_pat;

  logic               xfer;
  logic               unit_end;
  logic               state_last;
  logic               take;
  logic               enter_mark;
  logic [PAT_W-1:0]   cur_sh;
  logic [PAT_W-1:0]   nxt_sh;

  morse_rom u_rom (
    .code_i  (in_code),
    .valid_o (rom_valid),
    .len_o   (rom_len),
    .pat_o   (rom_pat)
  );

  assign xfer       = in_valid && ready_q;
  assign unit_end   = (presc_q == PRESC_LAST);
  assign cur_sh     = pat_q << idx_q;
  assign state_last = unit_end &&
                      (unit_q == UNIT_W'(state_units(state_q, cur_sh[PAT_W-1]) - 1));

  // Next-state, counters and registered outputs.
  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    unit_d  = unit_q;
    idx_d   = idx_q;
    len_d   = len_q;
    pat_d   = pat_q;
    err_d   = 1'b0;
    take    = 1'b0;

    case (state_q)
      IDLE:     take = xfer;
      MARK:     if (state_last) state_d = (idx_q == len_q - IDX_W'(1)) ? CHAR_GAP : ELEM_GAP;
      ELEM_GAP: if (state_last) begin
                  state_d = MARK;
                  idx_d   = idx_q + IDX_W'(1);
                end
      CHAR_GAP,
      WORD_GAP: if (state_last) begin
                  state_d = IDLE;
                  take    = xfer;
                end
      default:  state_d = IDLE;
    endcase

    // An invalid code from a gap still owes the line a fresh character gap.
    if (take) begin
      if (rom_valid) begin
        state_d = MARK;
        idx_d   = '0;
        len_d   = rom_len;
        pat_d   = rom_pat;
      end else if (in_code == CODE_WORD_SPACE) begin
        state_d = WORD_GAP;
      end else begin
        err_d   = 1'b1;
        state_d = (state_q == IDLE) ? IDLE : CHAR_GAP;
      end
    end

    if (state_q == IDLE || state_last) begin
      presc_d = '0;
      unit_d  = '0;
    end else if (unit_end) begin
      presc_d = '0;
      unit_d  = unit_q + UNIT_W'(1);
    end else begin
      presc_d = presc_q + PRESC_W'(1);
    end

    nxt_sh     = pat_d << idx_d;
    enter_mark = (state_d == MARK) && (state_q != MARK);
    dot_d      = enter_mark && !nxt_sh[PAT_W-1];
    dash_d     = enter_mark && nxt_sh[PAT_W-1];
    dout_d     = (state_d == MARK);
    busy_d     = (state_d != IDLE);
    ready_d    = (state_d == IDLE) ||
                 (((state_d == CHAR_GAP) || (state_d == WORD_GAP)) &&
                  (presc_d == PRESC_LAST) &&
                  (unit_d == UNIT_W'(state_units(state_d, 1'b0) - 1)));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      presc_q <= '0;
      unit_q  <= '0;
      idx_q   <= '0;
      len_q   <= '0;
      pat_q   <= '0;
      dout_q  <= 1'b0;
      busy_q  <= 1'b0;
      ready_q <= 1'b1;
      dot_q   <= 1'b0;
      dash_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      unit_q  <= unit_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      pat_q   <= pat_d;
      dout_q  <= dout_d;
      busy_q  <= busy_d;
      ready_q <= ready_d;
      dot_q   <= dot_d;
      dash_q  <= dash_d;
      err_q   <= err_d;
    end
  end

  assign in_ready  = ready_q;
  assign dout      = dout_q;
  assign busy      = busy_q;
  assign elem_dot  = dot_q;
  assign elem_dash = dash_q;
  assign err       = err_q;

endmodule

// File: tb/tb_morse_keyer.sv
// Self-checking bench for morse_keyer: directed vector table, hand-written corner
// sequences and random code streams checked against a string-based Morse model.
module tb_morse_keyer;

  logic       clk;
  logic       reset;
  logic       v1, v5;
  logic [5:0] c1, c5;
  logic       r1, d1, b1, dot1, dash1, e1;
  logic       r5, d5, b5, dot5, dash5, e5;

  int n_tests;
  int n_fail;

  morse_keyer #(.UNIT_CYCLES(1), .PRESC_W(16)) u_dut1 (
    .clk(clk), .reset(reset), .in_valid(v1), .in_code(c1), .in_ready(r1),
    .dout(d1), .busy(b1), .elem_dot(dot1), .elem_dash(dash1), .err(e1)
  );

  morse_keyer #(.UNIT_CYCLES(5), .PRESC_W(16)) u_dut5 (
    .clk(clk), .reset(reset), .in_valid(v5), .in_code(c5), .in_ready(r5),
    .dout(d5), .busy(b5), .elem_dot(dot5), .elem_dash(dash5), .err(e5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    int         ncode;
    logic [5:0] c0, c1, c2;
    int         n;
    logic [63:0] bits;
    int         dots, dashes, errs;
  } vec_t;

  vec_t       tbl [10];
  string      mtab [36];
  logic [5:0] seq_q [$];
  bit         cap_q [$];
  bit         exp_q [$];
  int         cap_dots, cap_dashes, cap_errs;
  int         exp_dots, exp_dashes, exp_errs;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Offers seq_q back-to-back on DUT1 and captures ncap cycles starting after the first transfer.
  task automatic run_seq(input int ncap);
    int idx;
    bit xfer;
    bit started;
    int cyc;
    cap_q.delete();
    cap_dots = 0; cap_dashes = 0; cap_errs = 0;
    idx = 0; started = 0; cyc = 0;
    v1 = 1'b1;
    c1 = seq_q[0];
    xfer = v1 && r1;
    while (cap_q.size() < ncap && cyc < 2000) begin
      @(posedge clk); #1;
      cyc++;
      if (xfer) begin
        started = 1;
        idx++;
        if (idx < seq_q.size()) c1 = seq_q[idx];
        else v1 = 1'b0;
      end
      if (started) begin
        cap_q.push_back(d1);
        cap_dots   += int'(dot1);
        cap_dashes += int'(dash1);
        cap_errs   += int'(e1);
      end
      xfer = v1 && r1;
    end
    v1 = 1'b0;
    check("seq_capture_len", 64'(cap_q.size()), 64'(ncap));
    check("seq_all_consumed", 64'(idx), 64'(seq_q.size()));
  endtask

  // Expected line from Morse strings: dot=1 high, dash=3 high, 1 low between elements,
  // 3 low after a character, 4 low for a word space, invalid = 1 cycle from idle else 3 low.
  task automatic build_model();
    bit line_idle;
    line_idle = 1;
    exp_q.delete();
    exp_dots = 0; exp_dashes = 0; exp_errs = 0;
    foreach (seq_q[k]) begin
      int    c;
      string s;
      c = int'(seq_q[k]);
      if (c < 36) begin
        s = mtab[c];
        for (int j = 0; j < s.len(); j++) begin
          if (j > 0) exp_q.push_back(1'b0);
          if (s[j] == "-") begin
            repeat (3) exp_q.push_back(1'b1);
            exp_dashes++;
          end else begin
            exp_q.push_back(1'b1);
            exp_dots++;
          end
        end
        repeat (3) exp_q.push_back(1'b0);
        line_idle = 0;
      end else if (c == 36) begin
        repeat (4) exp_q.push_back(1'b0);
        line_idle = 0;
      end else begin
        exp_errs++;
        repeat (line_idle ? 1 : 3) exp_q.push_back(1'b0);
      end
    end
  endtask

  initial begin
    logic [63:0] got;
    logic [40:0] dv, rv, bv, tv, ev;
    int          cnt;
    int          first;

    n_tests = 0;
    n_fail  = 0;
    mtab = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..", ".---",
             "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.", "...", "-",
             "..-", "...-", ".--", "-..-", "-.--", "--..",
             "-----", ".----", "..---", "...--", "....-", ".....", "-....", "--...",
             "---..", "----."};

    tbl[0] = '{1, 6'd4,  6'd0,  6'd0,  4, 64'b1000, 1, 0, 0};
    tbl[1] = '{1, 6'd19, 6'd0,  6'd0,  6, 64'b111000, 0, 1, 0};
    tbl[2] = '{2, 6'd0,  6'd1,  6'd0, 20, 64'b10111000111010101000, 4, 2, 0};
    tbl[3] = '{3, 6'd4,  6'd36, 6'd19, 14, 64'b10000000111000, 1, 1, 0};
    tbl[4] = '{1, 6'd45, 6'd0,  6'd0,  1, 64'b0, 0, 0, 1};
    tbl[5] = '{1, 6'd26, 6'd0,  6'd0, 22, 64'b1110111011101110111000, 0, 5, 0};
    tbl[6] = '{3, 6'd18, 6'd63, 6'd4, 15, 64'b101010000001000, 4, 0, 1};
    tbl[7] = '{1, 6'd36, 6'd0,  6'd0,  4, 64'b0000, 0, 0, 0};
    tbl[8] = '{2, 6'd45, 6'd4,  6'd0,  5, 64'b01000, 1, 0, 1};
    tbl[9] = '{1, 6'd16, 6'd0,  6'd0, 16, 64'b1110111010111000, 1, 3, 0};

    reset = 1'b1; v1 = 1'b0; c1 = '0; v5 = 1'b0; c5 = '0;
    idle(2);
    check("reset_state_u1", 64'({d1, b1, r1, e1, dot1, dash1}), 64'(6'b001000));
    check("reset_state_u5", 64'({d5, b5, r5, e5, dot5, dash5}), 64'(6'b001000));
    reset = 1'b0;
    idle(2);

    // Directed vector table.
    for (int t = 0; t < 10; t++) begin
      seq_q.delete();
      seq_q.push_back(tbl[t].c0);
      if (tbl[t].ncode > 1) seq_q.push_back(tbl[t].c1);
      if (tbl[t].ncode > 2) seq_q.push_back(tbl[t].c2);
      idle(3);
      run_seq(tbl[t].n);
      got = '0;
      foreach (cap_q[i]) got = {got[62:0], cap_q[i]};
      check($sformatf("vec%0d_dout", t), got, tbl[t].bits);
      check($sformatf("vec%0d_dots", t), 64'(cap_dots), 64'(tbl[t].dots));
      check($sformatf("vec%0d_dashes", t), 64'(cap_dashes), 64'(tbl[t].dashes));
      check($sformatf("vec%0d_errs", t), 64'(cap_errs), 64'(tbl[t].errs));
      idle(1);
      check($sformatf("vec%0d_idle_after", t), 64'({b1, r1}), 64'(2'b01));
    end

    // 'E' cycle-exact timing.
    idle(3);
    v1 = 1'b1; c1 = 6'd4;
    dv = '0; rv = '0; bv = '0; tv = '0;
    for (int i = 1; i <= 5; i++) begin
      @(posedge clk); #1;
      if (i == 1) v1 = 1'b0;
      dv[i] = d1; rv[i] = r1; bv[i] = b1; tv[i] = dot1;
    end
    check("e_dout_c1_4", 64'({dv[1], dv[2], dv[3], dv[4]}), 64'(4'b1000));
    check("e_dot_pulse", 64'({tv[1], tv[2]}), 64'(2'b10));
    check("e_ready_c3_4", 64'({rv[3], rv[4]}), 64'(2'b01));
    check("e_busy_c4_5", 64'({bv[4], bv[5]}), 64'(2'b10));

    // Invalid code from IDLE.
    idle(3);
    v1 = 1'b1; c1 = 6'd45;
    dv = '0; rv = '0; bv = '0; ev = '0;
    for (int i = 1; i <= 2; i++) begin
      @(posedge clk); #1;
      if (i == 1) v1 = 1'b0;
      dv[i] = d1; rv[i] = r1; bv[i] = b1; ev[i] = e1;
    end
    check("inv_err_pulse", 64'({ev[1], ev[2]}), 64'(2'b10));
    check("inv_line_ready_busy", 64'({dv[1], dv[2], rv[1], rv[2], bv[1], bv[2]}), 64'(6'b001100));

    // UNIT_CYCLES=5 'T'.
    idle(3);
    v5 = 1'b1; c5 = 6'd19;
    dv = '0; rv = '0; bv = '0; tv = '0; cnt = 0;
    for (int i = 1; i <= 32; i++) begin
      @(posedge clk); #1;
      if (i == 1) v5 = 1'b0;
      dv[i] = d5; rv[i] = r5; bv[i] = b5; tv[i] = dash5;
      cnt += int'(dash5);
    end
    got = '0;
    for (int i = 1; i <= 30; i++) got = {got[62:0], dv[i]};
    check("u5_t_dout", got, 64'h3FFF8000);
    check("u5_t_dash_count", 64'(cnt), 64'd1);
    check("u5_t_dash_first", 64'(tv[1]), 64'd1);
    check("u5_t_ready_c29_30", 64'({rv[29], rv[30]}), 64'(2'b01));
    check("u5_t_busy_c30_31", 64'({bv[30], bv[31]}), 64'(2'b10));

    // Reset on the 2nd cycle of the first dash of 'O'.
    idle(3);
    v1 = 1'b1; c1 = 6'd14;
    idle(1);
    v1 = 1'b0;
    idle(1);
    check("o_dash_mark_c2", 64'({d1, b1}), 64'(2'b11));
    reset = 1'b1;
    idle(1);
    check("o_reset_abort", 64'({d1, b1, r1}), 64'(3'b001));
    reset = 1'b0;
    idle(1);
    check("o_stays_low", 64'({d1, b1}), 64'(2'b00));
    seq_q.delete();
    seq_q.push_back(6'd4);
    run_seq(4);
    got = '0;
    foreach (cap_q[i]) got = {got[62:0], cap_q[i]};
    check("e_after_reset_dout", got, 64'b1000);

    // Reset and transfer together: the code is dropped.
    idle(3);
    reset = 1'b1; v1 = 1'b1; c1 = 6'd4;
    idle(1);
    reset = 1'b0; v1 = 1'b0;
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      idle(1);
      cnt += int'(d1) + int'(b1);
    end
    check("reset_beats_transfer", 64'(cnt), 64'd0);

    // Random back-to-back streams against the model.
    for (int r = 0; r < 8; r++) begin
      int n;
      seq_q.delete();
      n = int'($urandom_range(3, 7));
      for (int k = 0; k < n; k++) begin
        int p;
        int code;
        p = int'($urandom_range(0, 99));
        if (p < 70)      code = int'($urandom_range(0, 35));
        else if (p < 85) code = 36;
        else             code = int'($urandom_range(37, 63));
        seq_q.push_back(6'(code));
      end
      build_model();
      idle(3);
      run_seq(exp_q.size());
      first = -1;
      for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++)
        if (first < 0 && cap_q[i] != exp_q[i]) first = i;
      check($sformatf("rand%0d_first_dout_diff", r), 64'(first), 64'(-1));
      check($sformatf("rand%0d_dots", r), 64'(cap_dots), 64'(exp_dots));
      check($sformatf("rand%0d_dashes", r), 64'(cap_dashes), 64'(exp_dashes));
      check($sformatf("rand%0d_errs", r), 64'(cap_errs), 64'(exp_errs));
    end

    idle(2);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
